// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter_pkg
// Brief  : Shared types for the unified memory port arbiter (FSM states and
//          transaction owner encoding).
// Rev    : 1.0  initial release
// ============================================================================
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RSP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_t;

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter_if
// Brief  : Bundle of fetch, load/store and memory-side handshake signals.
//          slave  = arbiter view, master = requesters plus memory view.
// Rev    : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // instruction fetch side
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_data;

  // load/store side
  logic                if_unused_pad;
  logic                d_req_valid;
  logic                d_req_ready;
  logic [ADDR_W-1:0]   d_addr;
  logic                d_we;
  logic [DATA_W-1:0]   d_wdata;
  logic [DATA_W/8-1:0] d_be;
  logic                d_rsp_valid;
  logic [DATA_W-1:0]   d_rsp_data;

  // memory side
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_be;
  logic                mem_rsp_valid;
  logic [DATA_W-1:0]   mem_rsp_data;

  modport slave (
    input  if_req_valid, if_addr,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    input  d_req_valid, d_addr, d_we, d_wdata, d_be,
    output d_req_ready, d_rsp_valid, d_rsp_data,
    output mem_req_valid, mem_addr, mem_we, mem_wdata, mem_be,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport master (
    output if_req_valid, if_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    output d_req_valid, d_addr, d_we, d_wdata, d_be,
    input  d_req_ready, d_rsp_valid, d_rsp_data,
    input  mem_req_valid, mem_addr, mem_we, mem_wdata, mem_be,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

endinterface : mem_port_arbiter_if
`default_nettype wire

// File: rtl/mem_port_arbiter_prio_sel.sv
`default_nettype none
// ============================================================================
// Module : arb_prio_sel
// Brief  : Winner select between fetch and load/store. Data wins by default;
//          a saturating streak of data grants taken while fetch waits forces
//          one fetch grant once it reaches MAX_DATA_STREAK.
// Rev    : 1.0  initial release
// ============================================================================
module arb_prio_sel #(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic idle,
  input  logic if_valid,
  input  logic d_valid,
  output logic grant_if,
  output logic grant_d
);

  localparam int                  STREAK_W   = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  logic [STREAK_W-1:0] streak;
  logic                if_forced;

  // Fetch takes precedence only once data has starved it for the full streak.
  assign if_forced = if_valid && (streak == STREAK_MAX);
  assign grant_d   = idle && d_valid && !if_forced;
  assign grant_if  = idle && if_valid && !grant_d;

  // Streak counts data grants while fetch waits; only IDLE cycles update it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (idle) begin
      if (!if_valid || grant_if) begin
        streak <= '0;
      end else if (grant_d && (streak != STREAK_MAX)) begin
        streak <= streak + 1'b1;
      end
    end
  end

endmodule : arb_prio_sel
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter
// Brief  : Shares one memory port between instruction fetch and load/store.
//          One outstanding transaction: IDLE (arbitrate) -> REQ (present
//          registered request) -> RSP (forward response to owner).
// Rev    : 1.0  initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  arb_state_t          state;
  arb_owner_t          owner;
  logic                req_valid_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] be_q;

  logic arbitrating;
  logic grant_if;
  logic grant_d;
  logic rsp_fire;

  // rst_n gates arbitration so no ready leaks out while reset is held.
  assign arbitrating = rst_n && (state == ARB_IDLE);

  arb_prio_sel #(
    .MAX_DATA_STREAK (MAX_DATA_STREAK)
  ) u_prio_sel (
    .clk      (clk),
    .rst_n    (rst_n),
    .idle     (arbitrating),
    .if_valid (bus.if_req_valid),
    .d_valid  (bus.d_req_valid),
    .grant_if (grant_if),
    .grant_d  (grant_d)
  );

  // Ready is the grant itself, so a grant is always a completed handshake.
  assign bus.if_req_ready = grant_if;
  assign bus.d_req_ready  = grant_d;

  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_we        = we_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_be        = be_q;

  // Responses only count in RSP; stray pulses elsewhere are dropped.
  assign rsp_fire         = (state == ARB_RSP) && bus.mem_rsp_valid;
  assign bus.if_rsp_valid = rsp_fire && (owner == OWN_IF);
  assign bus.d_rsp_valid  = rsp_fire && (owner == OWN_D);
  assign bus.if_rsp_data  = bus.if_rsp_valid ? bus.mem_rsp_data : '0;
  assign bus.d_rsp_data   = bus.d_rsp_valid  ? bus.mem_rsp_data : '0;

  // Transaction FSM with registered memory request fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      owner       <= OWN_IF;
      req_valid_q <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_d) begin
            owner       <= OWN_D;
            addr_q      <= bus.d_addr;
            we_q        <= bus.d_we;
            wdata_q     <= bus.d_wdata;
            be_q        <= bus.d_be;
            req_valid_q <= 1'b1;
            state       <= ARB_REQ;
          end else if (grant_if) begin
            owner       <= OWN_IF;
            addr_q      <= bus.if_addr;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '1;
            req_valid_q <= 1'b1;
            state       <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (bus.mem_req_ready) begin
            req_valid_q <= 1'b0;
            state       <= ARB_RSP;
          end
        end
        ARB_RSP: begin
          if (bus.mem_rsp_valid) begin
            state <= ARB_IDLE;
          end
        end
        default: begin
          req_valid_q <= 1'b0;
          state       <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_port_arbiter
// Brief  : Directed self-checking bench for mem_port_arbiter. Inputs change
//          1ns after the rising edge; outputs are sampled 1ns later.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W          (32),
    .DATA_W          (32),
    .MAX_DATA_STREAK (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.if_req_valid  = 1'b0;
    bus.if_addr       = '0;
    bus.d_req_valid   = 1'b0;
    bus.d_addr        = '0;
    bus.d_we          = 1'b0;
    bus.d_wdata       = '0;
    bus.d_be          = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    bus.if_req_valid = 1'b1;
    bus.d_req_valid  = 1'b1;
    bus.d_addr       = 32'h40;
    bus.if_addr      = 32'h44;
    cyc(); cyc(); cyc();
    #1;
    total++;
    if ({bus.if_req_ready, bus.d_req_ready, bus.mem_req_valid, bus.if_rsp_valid, bus.d_rsp_valid} !== 5'b0) begin
      bad++;
      $display("FAIL rst_ctrl_outputs: got %b want 00000",
               {bus.if_req_ready, bus.d_req_ready, bus.mem_req_valid, bus.if_rsp_valid, bus.d_rsp_valid});
    end
    total++;
    if ({bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.mem_be, bus.if_rsp_data, bus.d_rsp_data} !== '0) begin
      bad++;
      $display("FAIL rst_data_outputs: got addr=%h we=%b wdata=%h be=%h want all zero",
               bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.mem_be);
    end
    // release mid-cycle: data must win the very first arbitration
    rst_n = 1'b1;
    #1;
    total++;
    if ({bus.d_req_ready, bus.if_req_ready} !== 2'b10) begin
      bad++;
      $display("FAIL rst_release_grant: got d/if=%b want 10", {bus.d_req_ready, bus.if_req_ready});
    end
    cyc();
    bus.d_req_valid   = 1'b0;
    bus.if_req_valid  = 1'b0;
    bus.mem_req_ready = 1'b1;
    #1;
    total++;
    if ({bus.mem_req_valid, bus.mem_addr} !== {1'b1, 32'h40}) begin
      bad++;
      $display("FAIL rst_first_req: got valid=%b addr=%h want 1 00000040", bus.mem_req_valid, bus.mem_addr);
    end
    cyc();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h11112222;
    #1;
    total++;
    if ({bus.d_rsp_valid, bus.if_rsp_valid, bus.d_rsp_data} !== {2'b10, 32'h11112222}) begin
      bad++;
      $display("FAIL rst_first_rsp: got d/if=%b data=%h want 10 11112222",
               {bus.d_rsp_valid, bus.if_rsp_valid}, bus.d_rsp_data);
    end
  endtask

  task automatic test_if_fetch();
    cyc();
    clear_inputs();
    bus.if_req_valid = 1'b1;
    bus.if_addr      = 32'h100;
    #1;
    total++;
    if ({bus.if_req_ready, bus.d_req_ready} !== 2'b10) begin
      bad++;
      $display("FAIL fetch_grant: got if/d=%b want 10", {bus.if_req_ready, bus.d_req_ready});
    end
    cyc();
    bus.if_req_valid  = 1'b0;
    bus.if_addr       = 32'hBAD0;
    bus.mem_req_ready = 1'b1;
    #1;
    total++;
    if ({bus.mem_req_valid, bus.mem_addr, bus.mem_we, bus.mem_be, bus.mem_wdata} !== {1'b1, 32'h100, 1'b0, 4'hF, 32'h0}) begin
      bad++;
      $display("FAIL fetch_req_fields: got v=%b a=%h we=%b be=%h wd=%h want 1 00000100 0 f 00000000",
               bus.mem_req_valid, bus.mem_addr, bus.mem_we, bus.mem_be, bus.mem_wdata);
    end
    cyc();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h00500093;
    #1;
    total++;
    if ({bus.if_rsp_valid, bus.d_rsp_valid, bus.if_rsp_data} !== {2'b10, 32'h00500093}) begin
      bad++;
      $display("FAIL fetch_rsp: got if/d=%b data=%h want 10 00500093",
               {bus.if_rsp_valid, bus.d_rsp_valid}, bus.if_rsp_data);
    end
    cyc();
    bus.mem_rsp_valid = 1'b0;
    #1;
    total++;
    if ({bus.if_rsp_valid, bus.mem_req_valid} !== 2'b00) begin
      bad++;
      $display("FAIL fetch_rsp_pulse: got rsp/req=%b want 00", {bus.if_rsp_valid, bus.mem_req_valid});
    end
  endtask

  task automatic test_streak();
    logic [9:0] exp_if;
    logic [31:0] exp_addr;
    exp_if = 10'b10000_10000;
    for (int i = 0; i < 10; i++) begin
      cyc();
      clear_inputs();
      bus.if_req_valid = 1'b1;
      bus.d_req_valid  = 1'b1;
      bus.d_addr       = 32'h300 + 32'(i);
      bus.if_addr      = 32'h400 + 32'(i);
      exp_addr         = exp_if[i] ? 32'h400 + 32'(i) : 32'h300 + 32'(i);
      #1;
      total++;
      if ({bus.if_req_ready, bus.d_req_ready} !== {exp_if[i], ~exp_if[i]}) begin
        bad++;
        $display("FAIL streak_grant[%0d]: got if/d=%b want %b", i,
                 {bus.if_req_ready, bus.d_req_ready}, {exp_if[i], ~exp_if[i]});
      end
      cyc();
      bus.mem_req_ready = 1'b1;
      #1;
      total++;
      if ({bus.mem_req_valid, bus.mem_addr} !== {1'b1, exp_addr}) begin
        bad++;
        $display("FAIL streak_addr[%0d]: got v=%b a=%h want 1 %h", i, bus.mem_req_valid, bus.mem_addr, exp_addr);
      end
      cyc();
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'hA000 + 32'(i);
      #1;
      total++;
      if ({bus.if_rsp_valid, bus.d_rsp_valid} !== {exp_if[i], ~exp_if[i]}) begin
        bad++;
        $display("FAIL streak_rsp[%0d]: got if/d=%b want %b", i,
                 {bus.if_rsp_valid, bus.d_rsp_valid}, {exp_if[i], ~exp_if[i]});
      end
    end
  endtask

  task automatic test_store_wait();
    cyc();
    clear_inputs();
    bus.if_req_valid = 1'b1;
    bus.if_addr      = 32'h700;
    bus.d_req_valid  = 1'b1;
    bus.d_we         = 1'b1;
    bus.d_addr       = 32'h200;
    bus.d_wdata      = 32'hDEADBEEF;
    bus.d_be         = 4'h3;
    #1;
    total++;
    if ({bus.d_req_ready, bus.if_req_ready} !== 2'b10) begin
      bad++;
      $display("FAIL store_grant: got d/if=%b want 10", {bus.d_req_ready, bus.if_req_ready});
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      bus.d_req_valid   = 1'b0;
      bus.d_addr        = 32'hFFF;
      bus.d_wdata       = 32'h0;
      bus.d_be          = 4'hC;
      bus.mem_req_ready = (k == 3);
      #1;
      total++;
      if ({bus.mem_req_valid, bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.mem_be, bus.if_req_ready, bus.d_rsp_valid}
          !== {1'b1, 32'h200, 1'b1, 32'hDEADBEEF, 4'h3, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL store_hold[%0d]: got v=%b a=%h we=%b wd=%h be=%h ifr=%b drsp=%b want 1 00000200 1 deadbeef 3 0 0",
                 k, bus.mem_req_valid, bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.mem_be,
                 bus.if_req_ready, bus.d_rsp_valid);
      end
    end
    cyc();
    bus.mem_req_ready = 1'b0;
    #1;
    total++;
    if ({bus.mem_req_valid, bus.d_rsp_valid, bus.if_req_ready} !== 3'b000) begin
      bad++;
      $display("FAIL store_rsp_wait: got req/rsp/ifr=%b want 000",
               {bus.mem_req_valid, bus.d_rsp_valid, bus.if_req_ready});
    end
    cyc();
    bus.mem_rsp_valid = 1'b1;
    #1;
    total++;
    if ({bus.d_rsp_valid, bus.if_rsp_valid, bus.if_req_ready} !== 3'b100) begin
      bad++;
      $display("FAIL store_ack: got d/if/ifr=%b want 100", {bus.d_rsp_valid, bus.if_rsp_valid, bus.if_req_ready});
    end
    cyc();
    bus.mem_rsp_valid = 1'b0;
    bus.if_req_valid  = 1'b0;
    #1;
    total++;
    if (bus.d_rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL store_ack_pulse: got %b want 0", bus.d_rsp_valid);
    end
  endtask

  task automatic test_stray_rsp();
    cyc();
    clear_inputs();
    bus.mem_rsp_valid = 1'b1;
    #1;
    total++;
    if ({bus.if_rsp_valid, bus.d_rsp_valid} !== 2'b00) begin
      bad++;
      $display("FAIL stray_idle: got if/d=%b want 00", {bus.if_rsp_valid, bus.d_rsp_valid});
    end
    cyc();
    bus.mem_rsp_valid = 1'b0;
    bus.d_req_valid   = 1'b1;
    bus.d_addr        = 32'h80;
    #1;
    total++;
    if (bus.d_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL stray_grant: got %b want 1", bus.d_req_ready);
    end
    cyc();
    bus.d_req_valid   = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    #1;
    total++;
    if ({bus.if_rsp_valid, bus.d_rsp_valid, bus.mem_req_valid} !== 3'b001) begin
      bad++;
      $display("FAIL stray_req: got if/d/req=%b want 001", {bus.if_rsp_valid, bus.d_rsp_valid, bus.mem_req_valid});
    end
    cyc();
    bus.mem_rsp_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    #1;
    total++;
    if (bus.mem_req_valid !== 1'b1) begin
      bad++;
      $display("FAIL stray_req_held: got %b want 1", bus.mem_req_valid);
    end
    cyc();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h12345678;
    #1;
    total++;
    if ({bus.d_rsp_valid, bus.if_rsp_valid, bus.d_rsp_data} !== {2'b10, 32'h12345678}) begin
      bad++;
      $display("FAIL stray_real_rsp: got d/if=%b data=%h want 10 12345678",
               {bus.d_rsp_valid, bus.if_rsp_valid}, bus.d_rsp_data);
    end
    cyc();
    #1;
    total++;
    if ({bus.d_rsp_valid, bus.if_rsp_valid} !== 2'b00) begin
      bad++;
      $display("FAIL stray_once: got d/if=%b want 00", {bus.d_rsp_valid, bus.if_rsp_valid});
    end
    bus.mem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset_mid_txn();
    cyc();
    clear_inputs();
    bus.if_req_valid = 1'b1;
    bus.if_addr      = 32'h500;
    #1;
    total++;
    if (bus.if_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL midrst_grant: got %b want 1", bus.if_req_ready);
    end
    cyc();
    bus.if_req_valid  = 1'b0;
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.mem_req_valid, bus.if_rsp_valid, bus.if_req_ready, bus.mem_addr} !== {3'b000, 32'h0}) begin
      bad++;
      $display("FAIL midrst_clear: got req/rsp/rdy=%b addr=%h want 000 00000000",
               {bus.mem_req_valid, bus.if_rsp_valid, bus.if_req_ready}, bus.mem_addr);
    end
    cyc();
    rst_n             = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hBADBAD00;
    #1;
    total++;
    if ({bus.if_rsp_valid, bus.d_rsp_valid, bus.mem_req_valid} !== 3'b000) begin
      bad++;
      $display("FAIL midrst_late_rsp: got if/d/req=%b want 000",
               {bus.if_rsp_valid, bus.d_rsp_valid, bus.mem_req_valid});
    end
    cyc();
    bus.mem_rsp_valid = 1'b0;
    bus.if_req_valid  = 1'b1;
    bus.if_addr       = 32'h600;
    #1;
    total++;
    if (bus.if_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL midrst_new_grant: got %b want 1", bus.if_req_ready);
    end
    cyc();
    bus.if_req_valid  = 1'b0;
    bus.mem_req_ready = 1'b1;
    #1;
    total++;
    if ({bus.mem_req_valid, bus.mem_addr} !== {1'b1, 32'h600}) begin
      bad++;
      $display("FAIL midrst_new_req: got v=%b a=%h want 1 00000600", bus.mem_req_valid, bus.mem_addr);
    end
    cyc();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hCAFE0001;
    #1;
    total++;
    if ({bus.if_rsp_valid, bus.if_rsp_data} !== {1'b1, 32'hCAFE0001}) begin
      bad++;
      $display("FAIL midrst_new_rsp: got v=%b data=%h want 1 cafe0001", bus.if_rsp_valid, bus.if_rsp_data);
    end
    cyc();
    clear_inputs();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_if_fetch();
    test_streak();
    test_store_wait();
    test_stray_rsp();
    test_reset_mid_txn();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
